wb_stream_writer_core: RTL and testbench
========================================

WB_STREAM_WRITER_CORE -- requirements
Module: wb_stream_writer_core

Interface
REQ-001 SHALL have parameter WB_AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter WB_DW, default 32, data width; word address step is 4.
REQ-003 SHALL have parameter FIFO_AW, default 4, FIFO depth 2^FIFO_AW words.
REQ-004 SHALL have ports, in this order:
- wb_clk_i  in  1  sole clock, all logic on rising edge
- wb_rst_n_i  in  1  asynchronous active-low reset
- stream_s_data_i  in  WB_DW  input stream word
- stream_s_valid_i  in  1  word valid
- stream_s_ready_o  out  1  word accepted when valid&ready
- wbm_adr_o  out  WB_AW  byte address
- wbm_dat_o  out  WB_DW  write data
- wbm_sel_o  out  WB_DW/8  byte selects, all ones during a cycle
- wbm_we_o  out  1  high during a cycle
- wbm_cyc_o / wbm_stb_o  out  1 each  bus cycle / strobe
- wbm_cti_o  out  3  cycle type
- wbm_bte_o  out  2  always 2'b00
- wbm_ack_i / wbm_err_i  in  1 each  slave ack / error
- enable  in  1  start request
- start_adr, buf_size, burst_size  in  WB_AW each  base byte address, total words, words per burst
- busy  out  1  transfer in progress
- tx_cnt  out  WB_DW  words written in current transfer
- err_o  out  1  sticky bus-error flag

Function
REQ-005 SHALL implement states IDLE, FILL, BURST, FINISH.
REQ-006 In IDLE, enable=1 SHALL latch start_adr/buf_size/burst_size, clear tx_cnt, rx_cnt and err_o, and go to FILL with busy=1 the next cycle; enable is ignored outside IDLE.
REQ-007 buf_size=0 SHALL go IDLE->FINISH->IDLE, busy high exactly one cycle, no bus cycle.
REQ-008 burst_size=0 SHALL be treated as 1.
REQ-009 Burst length L SHALL be min(burst_size, buf_size - tx_cnt).
REQ-010 stream_s_ready_o SHALL be busy & FIFO not full & rx_cnt < buf_size; never more than buf_size words accepted per transfer.
REQ-011 FILL SHALL go to BURST in the cycle after the FIFO holds at least L words; cyc/stb assert on BURST entry.
REQ-012 wbm_adr_o SHALL equal latched start_adr + 4*tx_cnt, width-truncated (wraps modulo 2^WB_AW); wbm_dat_o is the FIFO head.
REQ-013 wbm_cti_o SHALL be 3'b010 on every beat except the last of a burst, which is 3'b111; L=1 gives 3'b111.
REQ-014 Each ack SHALL pop the FIFO and increment tx_cnt in the same edge; stb stays high between beats.
REQ-015 cyc/stb SHALL deassert the cycle after the last ack; then FILL if tx_cnt<buf_size, else FINISH.
REQ-016 FINISH SHALL last one cycle and return to IDLE; busy is low from IDLE entry.
REQ-017 Simultaneous stream push and bus pop SHALL keep FIFO occupancy unchanged.
REQ-018 tx_cnt SHALL hold its final value in IDLE until the next accepted enable.

Reset
REQ-019 wb_rst_n_i low SHALL asynchronously force IDLE, FIFO empty, rx_cnt=0, and every output 0 (wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o, stream_s_ready_o, busy, tx_cnt, err_o); release is synchronous to wb_clk_i.
REQ-020 Reset mid-burst SHALL drop cyc/stb immediately, discard FIFO contents, not resume.

Configuration
REQ-021 With WB_STREAM_WRITER_ERR_EN defined, wbm_err_i during BURST SHALL end the cycle next edge, set err_o, flush the FIFO, go to FINISH; no further bus cycles.
REQ-022 Without WB_STREAM_WRITER_ERR_EN, wbm_err_i SHALL be ignored and err_o tied 0.

Verification
REQ-023 start_adr=0x1000, buf_size=8, burst_size=4, 8 words streamed, ack every cycle -> two bursts 0x1000-0x100C and 0x1010-0x101C, cti 010,010,010,111 each, tx_cnt=8, busy falls.
REQ-024 buf_size=5, burst_size=4 -> bursts of 4 then 1 (cti 111 alone at 0x1010); 6th stream word not accepted (ready low).
REQ-025 buf_size=0, enable pulse -> busy high exactly 1 cycle, wbm_cyc_o never asserts.
REQ-026 ack stalled 3 cycles mid-burst, stream continuous -> stb/adr/dat held stable, FIFO never overflows, no lost word.
REQ-027 ERR_EN defined, wbm_err_i on beat 2 -> cyc drops next edge, err_o=1, tx_cnt=1, FIFO empty; without ERR_EN same stimulus -> err_o=0, transfer continues.
REQ-028 wb_rst_n_i low during beat 3 -> all outputs 0 same cycle; new enable after release restarts at start_adr with tx_cnt=0.

Source files
------------

// File: rtl/wb_stream_writer_core.sv
// Stream-to-Wishbone writer: buffers an incoming valid/ready stream in a FIFO and writes it
// out as incrementing Wishbone bursts. Define WB_STREAM_WRITER_ERR_EN to abort on wbm_err_i.
module wb_stream_writer_core #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [WB_DW-1:0]   stream_s_data_i,
    input  logic               stream_s_valid_i,
    output logic               stream_s_ready_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               enable,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    output logic               busy,
    output logic [WB_DW-1:0]   tx_cnt,
    output logic               err_o
);

    localparam int                 DEPTH    = 1 << FIFO_AW;
    localparam logic [WB_AW-1:0]   DEPTH_W  = WB_AW'(DEPTH);
    localparam logic [WB_AW-1:0]   ONE_W    = WB_AW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   FILL_ONE = (FIFO_AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_FINISH} state_t;

    state_t           state_q, state_d;
    logic [WB_AW-1:0] start_adr_q, start_adr_d;
    logic [WB_AW-1:0] buf_size_q, buf_size_d;
    logic [WB_AW-1:0] burst_size_q, burst_size_d;
    logic [WB_AW-1:0] tx_cnt_q, tx_cnt_d;
    logic [WB_AW-1:0] rx_cnt_q, rx_cnt_d;
    logic [WB_AW-1:0] beats_q, beats_d;
    logic             err_q, err_d;

    logic [WB_DW-1:0]   fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   fill_q;
    logic               fifo_full, push, pop, flush, err_hit;
    logic [WB_AW-1:0]   remain, burst_eff, burst_len, tx_inc;

    assign fifo_full        = fill_q[FIFO_AW];
    assign stream_s_ready_o = (state_q == S_FILL || state_q == S_BURST) && !fifo_full
                              && (rx_cnt_q < buf_size_q);
    assign push             = stream_s_valid_i && stream_s_ready_o;
    assign tx_inc           = tx_cnt_q + ONE_W;

`ifdef WB_STREAM_WRITER_ERR_EN
    assign err_hit = (state_q == S_BURST) && wbm_err_i;
`else
    logic unused_err;
    assign unused_err = wbm_err_i;
    assign err_hit    = 1'b0;
`endif

    // Bursts longer than the FIFO could never fill, so the FIFO depth caps the burst length.
    always_comb begin
        remain    = buf_size_q - tx_cnt_q;
        burst_eff = (burst_size_q == '0) ? ONE_W : burst_size_q;
        if (burst_eff > DEPTH_W)
            burst_eff = DEPTH_W;
        burst_len = (burst_eff < remain) ? burst_eff : remain;
    end

    always_comb begin
        state_d      = state_q;
        start_adr_d  = start_adr_q;
        buf_size_d   = buf_size_q;
        burst_size_d = burst_size_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        beats_d      = beats_q;
        err_d        = err_q;
        pop          = 1'b0;
        flush        = 1'b0;
        if (push)
            rx_cnt_d = rx_cnt_q + ONE_W;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start_adr_d  = start_adr;
                    buf_size_d   = buf_size;
                    burst_size_d = burst_size;
                    tx_cnt_d     = '0;
                    rx_cnt_d     = '0;
                    err_d        = 1'b0;
                    state_d      = (buf_size == '0) ? S_FINISH : S_FILL;
                end
            end
            S_FILL: begin
                if (WB_AW'(fill_q) >= burst_len) begin
                    beats_d = burst_len;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (err_hit) begin
                    err_d   = 1'b1;
                    flush   = 1'b1;
                    state_d = S_FINISH;
                end else if (wbm_ack_i) begin
                    pop      = 1'b1;
                    tx_cnt_d = tx_inc;
                    beats_d  = beats_q - ONE_W;
                    if (beats_q == ONE_W)
                        state_d = (tx_inc < buf_size_q) ? S_FILL : S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= S_IDLE;
            start_adr_q  <= '0;
            buf_size_q   <= '0;
            burst_size_q <= '0;
            tx_cnt_q     <= '0;
            rx_cnt_q     <= '0;
            beats_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_adr_q  <= start_adr_d;
            buf_size_q   <= buf_size_d;
            burst_size_q <= burst_size_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            beats_q      <= beats_d;
            err_q        <= err_d;
        end
    end

    // A flush also drops any word pushed on the same edge; the transfer is being abandoned.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else if (flush) begin
            rptr_q <= wptr_q;
            fill_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + PTR_ONE;
            if (pop)
                rptr_q <= rptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + FILL_ONE;
                2'b01:   fill_q <= fill_q - FILL_ONE;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push)
            fifo_mem[wptr_q] <= stream_s_data_i;
    end

    // Bus outputs are gated by cyc so they read zero outside a cycle and during reset.
    assign wbm_cyc_o = (state_q == S_BURST);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o;
    assign wbm_sel_o = {(WB_DW/8){wbm_cyc_o}};
    assign wbm_adr_o = wbm_cyc_o ? (start_adr_q + {tx_cnt_q[WB_AW-3:0], 2'b00}) : '0;
    assign wbm_dat_o = wbm_cyc_o ? fifo_mem[rptr_q] : '0;
    assign wbm_cti_o = !wbm_cyc_o ? 3'b000 : ((beats_q == ONE_W) ? 3'b111 : 3'b010);
    assign wbm_bte_o = 2'b00;
    assign busy      = (state_q != S_IDLE);
    assign tx_cnt    = WB_DW'(tx_cnt_q);
    assign err_o     = err_q;

endmodule

// File: tb/tb_wb_stream_writer_core.sv
// Directed bench for wb_stream_writer_core: stream feeder, combinational ack/err responder
// and a beat logger; expected values are written out per vector.
module tb_wb_stream_writer_core;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic [DW-1:0] s_data     = '0;
    logic          s_valid    = 1'b0;
    logic          s_ready;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    logic          we, cyc, stb;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic          ack, err;
    logic          ack_en     = 1'b1;
    logic          err_en     = 1'b0;
    logic          enable     = 1'b0;
    logic [AW-1:0] start_adr  = '0;
    logic [AW-1:0] buf_size   = '0;
    logic [AW-1:0] burst_size = '0;
    logic          busy;
    logic [DW-1:0] tx_cnt;
    logic          err_o;
    logic          feed_stop  = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_busy = 0;
    int n_cyc_rise = 0;

    logic [AW-1:0] log_adr[$];
    logic [DW-1:0] log_dat[$];
    logic [2:0]    log_cti[$];
    logic [2:0]    exp_cti[$];

    logic          cyc_prev = 1'b0;
    logic          hold_v   = 1'b0;
    logic [AW-1:0] hold_adr = '0;
    logic [DW-1:0] hold_dat = '0;
    logic [2:0]    hold_cti = '0;

    assign ack = cyc & stb & ack_en & ~err_en;
    assign err = cyc & stb & err_en;

    always #5 clk = ~clk;

    wb_stream_writer_core dut (
        .wb_clk_i         (clk),
        .wb_rst_n_i       (rst_n),
        .stream_s_data_i  (s_data),
        .stream_s_valid_i (s_valid),
        .stream_s_ready_o (s_ready),
        .wbm_adr_o        (adr),
        .wbm_dat_o        (dat),
        .wbm_sel_o        (sel),
        .wbm_we_o         (we),
        .wbm_cyc_o        (cyc),
        .wbm_stb_o        (stb),
        .wbm_cti_o        (cti),
        .wbm_bte_o        (bte),
        .wbm_ack_i        (ack),
        .wbm_err_i        (err),
        .enable           (enable),
        .start_adr        (start_adr),
        .buf_size         (buf_size),
        .burst_size       (burst_size),
        .busy             (busy),
        .tx_cnt           (tx_cnt),
        .err_o            (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A beat still waiting for ack must keep adr/dat/cti steady on the next cycle.
    always @(negedge clk) begin
        if (s_valid && s_ready) n_acc++;
        if (busy) n_busy++;
        if (cyc && !cyc_prev) n_cyc_rise++;
        cyc_prev = cyc;
        if (cyc && hold_v) begin
            chk("hold_adr", adr, hold_adr);
            chk("hold_dat", dat, hold_dat);
            chk("hold_cti", cti, hold_cti);
        end
        hold_v   = cyc && !ack;
        hold_adr = adr;
        hold_dat = dat;
        hold_cti = cti;
        if (cyc && ack) begin
            log_adr.push_back(adr);
            log_dat.push_back(dat);
            log_cti.push_back(cti);
        end
    end

    task automatic feed(input logic [DW-1:0] base, input int n);
        int   k = 0;
        logic took;
        while (k < n && !feed_stop) begin
            s_valid = 1'b1;
            s_data  = base + DW'(k);
            @(negedge clk);
            took = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (took) k++;
        end
        s_valid = 1'b0;
    endtask

    task automatic stop_feed();
        feed_stop = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        feed_stop = 1'b0;
    endtask

    task automatic clear_log();
        log_adr.delete();
        log_dat.delete();
        log_cti.delete();
        n_acc      = 0;
        n_busy     = 0;
        n_cyc_rise = 0;
    endtask

    task automatic start(input logic [AW-1:0] a, input logic [AW-1:0] bs, input logic [AW-1:0] bu);
        start_adr  = a;
        buf_size   = bs;
        burst_size = bu;
        enable     = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t = 0;
        while (busy && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (log_adr.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(tag, log_adr.size() >= n, 1);
    endtask

    task automatic check_log(input string tag, input logic [AW-1:0] adr0, input logic [DW-1:0] dat0);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        chk({tag, "_beats"}, log_adr.size(), exp_cti.size());
        for (int i = 0; i < exp_cti.size() && i < log_adr.size(); i++) begin
            ea = adr0 + AW'(4 * i);
            ed = dat0 + DW'(i);
            chk($sformatf("%s_adr%0d", tag, i), log_adr[i], ea);
            chk($sformatf("%s_dat%0d", tag, i), log_dat[i], ed);
            chk($sformatf("%s_cti%0d", tag, i), log_cti[i], exp_cti[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_tx", tx_cnt, 0);
        chk("rst_err", err_o, 0);
        chk("rst_adr", adr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two full bursts of four
        clear_log();
        fork feed(32'hA000_0000, 8); join_none
        start(32'h1000, 8, 4);
        chk("t1_busy_on", busy, 1);
        wait_idle("t1", 200);
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b010, 3'b010, 3'b111};
        check_log("t1", 32'h1000, 32'hA000_0000);
        chk("t1_bursts", n_cyc_rise, 2);
        chk("t1_acc", n_acc, 8);
        chk("t1_tx", tx_cnt, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_tx_hold", tx_cnt, 8);
        stop_feed();

        // short tail burst, sixth word refused
        clear_log();
        fork feed(32'hB000_0000, 6); join_none
        start(32'h1000, 5, 4);
        wait_idle("t2", 200);
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b111};
        check_log("t2", 32'h1000, 32'hB000_0000);
        chk("t2_acc", n_acc, 5);
        chk("t2_bursts", n_cyc_rise, 2);
        chk("t2_tx", tx_cnt, 5);
        chk("t2_ready", s_ready, 0);
        stop_feed();

        // empty buffer
        clear_log();
        start(32'h1000, 0, 4);
        chk("t3_busy1", busy, 1);
        @(posedge clk);
        #1;
        chk("t3_busy0", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_nbusy", n_busy, 1);
        chk("t3_cyc", n_cyc_rise, 0);
        chk("t3_tx", tx_cnt, 0);

        // ack stalled three cycles on beat 2
        clear_log();
        fork feed(32'hC000_0000, 8); join_none
        start(32'h1000, 8, 4);
        wait_beats(1, "t4_beat1");
        ack_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_stall_cyc", cyc, 1);
        chk("t4_stall_tx", tx_cnt, 1);
        ack_en = 1'b1;
        wait_idle("t4", 200);
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b010, 3'b010, 3'b111};
        check_log("t4", 32'h1000, 32'hC000_0000);
        chk("t4_acc", n_acc, 8);
        stop_feed();

        // bus error on beat 2
        clear_log();
        fork feed(32'hD000_0000, 8); join_none
        start(32'h1000, 8, 4);
        wait_beats(1, "t5_beat1");
        err_en = 1'b1;
        @(posedge clk);
        #1;
        err_en = 1'b0;
`ifdef WB_STREAM_WRITER_ERR_EN
        chk("t5_cyc", cyc, 0);
        chk("t5_err", err_o, 1);
        chk("t5_tx", tx_cnt, 1);
        wait_idle("t5", 50);
        chk("t5_bursts", n_cyc_rise, 1);
        chk("t5_nbeats", log_adr.size(), 1);
        chk("t5_err_hold", err_o, 1);
`else
        chk("t5_cyc", cyc, 1);
        chk("t5_err", err_o, 0);
        chk("t5_tx", tx_cnt, 1);
        wait_idle("t5", 200);
        exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b010, 3'b010, 3'b111};
        check_log("t5", 32'h1000, 32'hD000_0000);
        chk("t5_err_end", err_o, 0);
        chk("t5_tx_end", tx_cnt, 8);
`endif
        stop_feed();

        // burst_size 0 acts as 1; fresh data proves no leftovers in the FIFO
        clear_log();
        fork feed(32'hE000_0000, 2); join_none
        start(32'h2000, 2, 0);
        chk("t5b_err_clr", err_o, 0);
        wait_idle("t5b", 100);
        exp_cti = '{3'b111, 3'b111};
        check_log("t5b", 32'h2000, 32'hE000_0000);
        chk("t5b_bursts", n_cyc_rise, 2);
        stop_feed();

        // reset during beat 3, then restart across the address wrap
        clear_log();
        fork feed(32'hF000_0000, 8); join_none
        start(32'h3000, 8, 4);
        wait_beats(2, "t6_beat2");
        chk("t6_pre_cyc", cyc, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", cyc, 0);
        chk("t6_stb", stb, 0);
        chk("t6_we", we, 0);
        chk("t6_sel", sel, 0);
        chk("t6_adr", adr, 0);
        chk("t6_dat", dat, 0);
        chk("t6_cti", cti, 0);
        chk("t6_bte", bte, 0);
        chk("t6_ready", s_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_tx", tx_cnt, 0);
        chk("t6_err", err_o, 0);
        stop_feed();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        fork feed(32'h1234_0000, 4); join_none
        start(32'hFFFF_FFF8, 4, 2);
        chk("t6_new_busy", busy, 1);
        chk("t6_new_tx", tx_cnt, 0);
        wait_idle("t6n", 100);
        exp_cti = '{3'b010, 3'b111, 3'b010, 3'b111};
        check_log("t6n", 32'hFFFF_FFF8, 32'h1234_0000);
        chk("t6_end_tx", tx_cnt, 4);
        stop_feed();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
